// File: rtl/interrupt_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_controller_pkg
//  Description : Shared definitions for the interrupt controller: FSM state
//                encoding, default flush length and the interrupt vector
//                address used by the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package interrupt_controller_pkg;

  // Controller FSM state encoding (3-bit, fixed values).
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_INJECT  = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_SERVICE = 3'd4
  } state_t;

  // Default number of cycles FlushReq stays high after an injection.
  localparam int c_FLUSH_CYCLES_DEF = 3;

  // Address the fetch stage redirects to when Int is taken in decode.
  localparam logic [31:0] c_INT_VECTOR_ADDR = 32'h0000_0100;

endpackage : interrupt_controller_pkg
`default_nettype wire

// File: rtl/interrupt_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_controller_if
//  Description : Pipeline-side signal bundle of the interrupt controller.
//                master = pipeline / environment, slave = controller.
//                INT_MASK_EN adds the IntEn enable input.
//  Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_controller_if #(
  parameter int PC_WIDTH   = 32,
  parameter int PEND_WIDTH = 2
);

  logic                  IntPin;
  logic                  Stall;
  logic                  CtrlInFlight;
  logic [PC_WIDTH-1:0]   FetchPc;
  logic                  RtiRetire;
`ifdef INT_MASK_EN
  logic                  IntEn;
`endif
  logic                  IntInject;
  logic                  FlushReq;
  logic                  InService;
  logic [PC_WIDTH-1:0]   SavedPc;
  logic [PEND_WIDTH-1:0] PendingCount;

`ifdef INT_MASK_EN
  modport master (
    output IntPin, Stall, CtrlInFlight, FetchPc, RtiRetire, IntEn,
    input  IntInject, FlushReq, InService, SavedPc, PendingCount
  );
  modport slave (
    input  IntPin, Stall, CtrlInFlight, FetchPc, RtiRetire, IntEn,
    output IntInject, FlushReq, InService, SavedPc, PendingCount
  );
`else
  modport master (
    output IntPin, Stall, CtrlInFlight, FetchPc, RtiRetire,
    input  IntInject, FlushReq, InService, SavedPc, PendingCount
  );
  modport slave (
    input  IntPin, Stall, CtrlInFlight, FetchPc, RtiRetire,
    output IntInject, FlushReq, InService, SavedPc, PendingCount
  );
`endif

endinterface : interrupt_controller_if
`default_nettype wire

// File: rtl/interrupt_controller_int_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : int_sync_edge
//  Description : SYNC_STAGES-deep synchronizer for the asynchronous interrupt
//                pin followed by a rising-edge detector. o_edge is a
//                single-cycle pulse, SYNC_STAGES cycles after the pin rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic Clk,
  input  wire logic Rst,
  input  wire logic i_async,
  output logic      o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the pin through the synchronizer and remember the last synced value.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule : int_sync_edge
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_controller
//  Description : Turns external interrupt pin edges into single-cycle Int
//                injections for decode, captures the return PC, flushes the
//                younger instructions and blocks re-entry until RTI retires.
//                Edges seen while busy are queued in a saturating counter.
//                Optional macro INT_MASK_EN: adds IntEn gating ARM->INJECT.
//  Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int PC_WIDTH     = 32,
  parameter int FLUSH_CYCLES = c_FLUSH_CYCLES_DEF,
  parameter int PEND_WIDTH   = 2
) (
  input wire logic              Clk,
  input wire logic              Rst,
  interrupt_controller_if.slave bus
);

  localparam int                    c_FC_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [c_FC_W-1:0]     c_FC_LOAD  = c_FC_W'(FLUSH_CYCLES - 1);
  localparam logic [PEND_WIDTH-1:0] c_PEND_MAX = {PEND_WIDTH{1'b1}};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_FC_W-1:0]     r_flush_cnt;
  logic [PEND_WIDTH-1:0] r_pend;
  logic [PC_WIDTH-1:0]   r_saved_pc;
  logic                  w_edge;
  logic                  w_arm_go;
  logic                  w_inject;

  int_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .Clk     (Clk),
    .Rst     (Rst),
    .i_async (bus.IntPin),
    .o_edge  (w_edge)
  );

  // Injection is only safe when nothing stalls and no control transfer is in ID/EX.
`ifdef INT_MASK_EN
  assign w_arm_go = ~bus.Stall & ~bus.CtrlInFlight & bus.IntEn;
`else
  assign w_arm_go = ~bus.Stall & ~bus.CtrlInFlight;
`endif

  assign w_inject = (r_state == ST_INJECT);

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; no nesting, so edges outside IDLE only queue up.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (r_pend != '0)         w_state_nxt = ST_ARM;
      ST_ARM:     if (w_arm_go)             w_state_nxt = ST_INJECT;
      ST_INJECT:                            w_state_nxt = ST_FLUSH;
      ST_FLUSH:   if (r_flush_cnt == '0)    w_state_nxt = ST_SERVICE;
      ST_SERVICE: if (bus.RtiRetire)        w_state_nxt = ST_IDLE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  // Flush down-counter: loaded as FLUSH is entered, ends the flush at zero.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_flush_cnt <= '0;
    end else if (r_state == ST_INJECT) begin
      r_flush_cnt <= c_FC_LOAD;
    end else if ((r_state == ST_FLUSH) && (r_flush_cnt != '0)) begin
      r_flush_cnt <= r_flush_cnt - 1'b1;
    end
  end

  // Pending counter: saturating +1 per edge, -1 per injection, net 0 if both.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pend <= '0;
    end else if (w_edge && !w_inject) begin
      if (r_pend != c_PEND_MAX) begin
        r_pend <= r_pend + 1'b1;
      end
    end else if (!w_edge && w_inject) begin
      r_pend <= r_pend - 1'b1;
    end
  end

  // Return address is captured during the injection cycle and held until the next one.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_saved_pc <= '0;
    end else if (w_inject) begin
      r_saved_pc <= bus.FetchPc;
    end
  end

  assign bus.IntInject    = w_inject;
  assign bus.FlushReq     = (r_state == ST_FLUSH);
  assign bus.InService    = (r_state == ST_SERVICE);
  assign bus.SavedPc      = r_saved_pc;
  assign bus.PendingCount = r_pend;

endmodule : interrupt_controller
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_controller
//  Description : Self-checking bench for interrupt_controller. Stimulus pushes
//                expected injections into a queue; a monitor pops and checks
//                them whenever IntInject is seen. Honors INT_MASK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

  localparam int SYNC_STAGES  = 2;
  localparam int PC_WIDTH     = 32;
  localparam int FLUSH_CYCLES = 3;
  localparam int PEND_WIDTH   = 2;

  typedef struct {
    int                  cyc;
    int                  pend;
    logic [PC_WIDTH-1:0] pc;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  interrupt_controller_if #(.PC_WIDTH(PC_WIDTH), .PEND_WIDTH(PEND_WIDTH)) bus ();

  interrupt_controller #(
    .SYNC_STAGES  (SYNC_STAGES),
    .PC_WIDTH     (PC_WIDTH),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .PEND_WIDTH   (PEND_WIDTH)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int   cyc        = 0;
  int   n_cmp      = 0;
  int   n_err      = 0;
  int   n_inj_seen = 0;
  int   n_inj_exp  = 0;
  int   flush_run  = 0;
  bit   flush_abort = 1'b0;
  bit   pc_chk_pending = 1'b0;
  logic [PC_WIDTH-1:0] pc_chk_val;
  exp_t q[$];
  exp_t mon_e;

  initial forever #5 Clk = ~Clk;
  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic expect_inject(input int c, input int p, input logic [PC_WIDTH-1:0] pc);
    exp_t e;
    e.cyc  = c;
    e.pend = p;
    e.pc   = pc;
    q.push_back(e);
    n_inj_exp++;
  endtask

  task automatic pin_pulse();
    bus.IntPin = 1'b1;
    tick(1);
    bus.IntPin = 1'b0;
  endtask

  task automatic rti_pulse();
    bus.RtiRetire = 1'b1;
    tick(1);
    bus.RtiRetire = 1'b0;
  endtask

  // Monitor: checks each injection against the scoreboard and each flush window.
  initial forever begin
    @(negedge Clk);
    if (pc_chk_pending) begin
      check("saved_pc", bus.SavedPc, pc_chk_val);
      pc_chk_pending = 1'b0;
    end
    if (bus.IntInject === 1'b1) begin
      n_inj_seen++;
      if (q.size() == 0) begin
        check("inject_queue_depth", q.size(), 1);
      end else begin
        mon_e = q.pop_front();
        check("inject_cycle", cyc, mon_e.cyc);
        check("pend_at_inject", bus.PendingCount, mon_e.pend);
        pc_chk_val     = mon_e.pc;
        pc_chk_pending = 1'b1;
      end
    end
    if (bus.FlushReq === 1'b1) begin
      flush_run++;
    end else if (flush_run > 0) begin
      if (!flush_abort) begin
        check("flush_len", flush_run, FLUSH_CYCLES);
        check("inservice_after_flush", bus.InService, 1);
      end
      flush_run   = 0;
      flush_abort = 1'b0;
    end
  end

  int p0;
  int s0;
  int r0;
  int exp_pend[4] = '{1, 2, 3, 3};

  initial begin
    bus.IntPin       = 1'b0;
    bus.Stall        = 1'b0;
    bus.CtrlInFlight = 1'b0;
    bus.FetchPc      = '0;
    bus.RtiRetire    = 1'b0;
`ifdef INT_MASK_EN
    bus.IntEn        = 1'b1;
`endif
    Rst = 1'b1;
    tick(3);
    Rst = 1'b0;
    check("rst_inject",  bus.IntInject, 0);
    check("rst_flush",   bus.FlushReq, 0);
    check("rst_service", bus.InService, 0);
    check("rst_savedpc", bus.SavedPc, 0);
    check("rst_pend",    bus.PendingCount, 0);
    tick(1);

    // Basic injection latency, SavedPc capture, 3-cycle flush then service.
    bus.FetchPc = 32'h0000_0040;
    p0 = cyc;
    expect_inject(p0 + SYNC_STAGES + 3, 1, 32'h0000_0040);
    pin_pulse();
    tick(9);
    check("t1_service", bus.InService, 1);
    check("t1_pend", bus.PendingCount, 0);
    rti_pulse();
    check("t1_idle_after_rti", bus.InService, 0);
    tick(2);

    // Stall held while armed: injection the cycle after Stall drops.
    bus.FetchPc = 32'h0000_0080;
    bus.Stall   = 1'b1;
    pin_pulse();
    tick(7);
    check("t2_no_service_while_stalled", bus.InService, 0);
    s0 = cyc;
    expect_inject(s0 + 1, 1, 32'h0000_0080);
    bus.Stall = 1'b0;
    tick(6);
    check("t2_service", bus.InService, 1);
    rti_pulse();
    tick(2);

    // Control transfer in ID/EX also holds the ARM state.
    bus.FetchPc      = 32'h0000_00C0;
    bus.CtrlInFlight = 1'b1;
    pin_pulse();
    tick(6);
    s0 = cyc;
    expect_inject(s0 + 1, 1, 32'h0000_00C0);
    bus.CtrlInFlight = 1'b0;
    tick(6);
    rti_pulse();
    tick(2);

    // Edges during service accumulate and saturate at 3.
    bus.FetchPc = 32'h0000_0100;
    p0 = cyc;
    expect_inject(p0 + 5, 1, 32'h0000_0100);
    pin_pulse();
    tick(9);
    for (int k = 0; k < 4; k++) begin
      pin_pulse();
      tick(3);
      check("t3_pend_accum", bus.PendingCount, exp_pend[k]);
    end
    check("t3_still_service", bus.InService, 1);
    bus.FetchPc = 32'h0000_0200;
    r0 = cyc;
    expect_inject(r0 + 3, 3, 32'h0000_0200);
    rti_pulse();
    tick(3);
    check("t3_pend_after_inject", bus.PendingCount, 2);
    tick(4);
    for (int d = 0; d < 2; d++) begin
      r0 = cyc;
      expect_inject(r0 + 3, 2 - d, 32'h0000_0200);
      rti_pulse();
      tick(7);
    end
    check("t3_drained", bus.PendingCount, 0);

    // RTI retire and a new edge in the same cycle.
    bus.FetchPc = 32'h0000_0300;
    p0 = cyc;
    expect_inject(p0 + 5, 1, 32'h0000_0300);
    bus.IntPin = 1'b1;
    tick(1);
    bus.IntPin = 1'b0;
    tick(1);
    rti_pulse();
    check("t4_pend", bus.PendingCount, 1);
    check("t4_idle", bus.InService, 0);
    tick(7);
    rti_pulse();
    tick(2);

    // Reset in the second flush cycle abandons the handler.
    bus.FetchPc = 32'h0000_1234;
    p0 = cyc;
    expect_inject(p0 + 5, 1, 32'h0000_1234);
    pin_pulse();
    tick(6);
    check("t5_in_flush", bus.FlushReq, 1);
    flush_abort = 1'b1;
    Rst = 1'b1;
    tick(1);
    Rst = 1'b0;
    check("t5_flush",   bus.FlushReq, 0);
    check("t5_service", bus.InService, 0);
    check("t5_pend",    bus.PendingCount, 0);
    check("t5_savedpc", bus.SavedPc, 0);
    check("t5_inject",  bus.IntInject, 0);
    tick(15);

`ifdef INT_MASK_EN
    // Masked: edge is queued, FSM waits in ARM until IntEn rises.
    bus.IntEn   = 1'b0;
    bus.FetchPc = 32'h0000_0400;
    pin_pulse();
    tick(8);
    check("t6_pend_masked", bus.PendingCount, 1);
    check("t6_no_flush", bus.FlushReq, 0);
    s0 = cyc;
    expect_inject(s0 + 1, 1, 32'h0000_0400);
    bus.IntEn = 1'b1;
    tick(6);
    rti_pulse();
    tick(2);
`endif

    tick(3);
    check("scoreboard_empty", q.size(), 0);
    check("inject_count", n_inj_seen, n_inj_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_interrupt_controller
`default_nettype wire

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sits upstream of the decode stage and drives the processor's Int input.
- Converts the asynchronous external interrupt pin into exactly one single-cycle injection pulse that the pipeline can accept safely.
- Captures the return PC, flushes younger instructions, and blocks re-entry until the RTI instruction retires in writeback.
- Queues interrupt edges that arrive while busy, using a saturating pending counter.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on IntPin (minimum 2).
- PC_WIDTH, 32, width of the fetch PC and of SavedPc.
- FLUSH_CYCLES, 3, number of cycles FlushReq is held after injection.
- PEND_WIDTH, 2, pending-counter width; the counter saturates at 2^PEND_WIDTH-1.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- IntPin  in  1  external interrupt request; asynchronous, rising-edge sensitive.
- Stall  in  1  pipeline stall from the load-use / hazard logic.
- CtrlInFlight  in  1  a jump, call, RET or RTI is in ID/EX.
- FetchPc  in  PC_WIDTH  PC of the next instruction to fetch.
- RtiRetire  in  1  one-cycle pulse when RTI reaches writeback.
- IntInject  out  1  one-cycle pulse that drives the decode stage's Int input.
- FlushReq  out  1  squash IF/ID and ID/EX contents.
- InService  out  1  an interrupt handler is executing.
- SavedPc  out  PC_WIDTH  latched return address.
- PendingCount  out  PEND_WIDTH  number of queued, unserviced edges.

Behaviour:
- Reset (synchronous, Rst=1 at a rising Clk edge):
  - synchronizer flops, edge register, counters and SavedPc all go to 0;
  - state goes to IDLE;
  - all outputs are 0 in the cycle after reset.
- Reset mid-operation abandons the handler immediately. No inject or flush pulse is emitted in that cycle.
- Edge detect:
  - an edge is sync_out=1 with the previous sync value 0;
  - latency from pin to detected edge is SYNC_STAGES+1 cycles.
- Pending counter:
  - +1 on each detected edge, saturating at its maximum (extra edges are dropped);
  - -1 on the cycle IntInject fires;
  - if an edge and an inject occur in the same cycle, the counter is unchanged.
- FSM states: IDLE, ARM, INJECT, FLUSH, SERVICE.
  - IDLE: PendingCount>0 -> ARM.
  - ARM: when Stall=0 and CtrlInFlight=0 in the same cycle -> INJECT; otherwise stay.
  - INJECT (exactly 1 cycle):
    - IntInject=1;
    - SavedPc<=FetchPc;
    - counter decrements;
    - next state is FLUSH.
  - FLUSH:
    - FlushReq=1 for exactly FLUSH_CYCLES consecutive cycles, counted by a down-counter loaded on entry;
    - then -> SERVICE.
    - Stall does not extend FLUSH.
  - SERVICE: InService=1; RtiRetire=1 -> IDLE.
- RtiRetire outside SERVICE is ignored.
- Edges arriving in any non-IDLE state only increment the counter. No nesting.
- SERVICE with RtiRetire and a new edge in the same cycle: go to IDLE, counter increments, then ARM on the next cycle.
- Re-arm latency from RTI retire to the next IntInject is at least 2 cycles (IDLE->ARM->INJECT).
- Outputs are registered, i.e. decoded from the state register. No combinational path from any input to any output.
- SavedPc holds its value until the next INJECT.

Optional Feature:
- Macro: INT_MASK_EN.
- Defined:
  - adds input IntEn (1 bit) after RtiRetire, driven by the set/clear-interrupt-enable instructions;
  - the ARM->INJECT transition additionally requires IntEn=1;
  - edges still accumulate in the pending counter while IntEn=0.
- Undefined:
  - no IntEn port; interrupts are always enabled;
  - behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the FSM state encoding (3-bit constants IDLE=0, ARM=1, INJECT=2, FLUSH=3, SERVICE=4);
  - the default FLUSH_CYCLES constant;
  - the interrupt vector address constant used by the fetch stage.
- One sub-module, int_sync_edge: SYNC_STAGES-deep synchronizer plus rising-edge detector, with Clk/Rst and a 1-bit edge pulse output.

Test Plan:
- Reset, then pulse IntPin for 1 cycle with Stall=0, FetchPc=0x00000040:
  - IntInject rises exactly SYNC_STAGES+3 cycles after the pin edge;
  - SavedPc=0x40;
  - FlushReq high for exactly 3 cycles, then InService=1.
- Edge arrives while Stall=1 for 5 cycles: FSM holds ARM, and IntInject fires the first cycle after Stall falls.
- Three edges during SERVICE: PendingCount goes 1,2,3, then a fourth edge leaves it at 3; after RtiRetire the next inject occurs 2 cycles later and PendingCount becomes 2.
- RtiRetire and a new edge in the same cycle in SERVICE: next state IDLE, PendingCount=1, IntInject follows 2 cycles later.
- Assert Rst during FLUSH (cycle 2 of 3): next cycle FlushReq=0, InService=0, PendingCount=0, SavedPc=0; no further inject.
- With INT_MASK_EN defined and IntEn=0:
  - an edge sets PendingCount=1 and the FSM sits in ARM;
  - setting IntEn=1 gives IntInject on the next cycle.
